// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
`timescale 1ns/1ps
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fq_state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fq_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fq_fifo.sv
// Small circular buffer of fetched {pc+4, instruction} entries with a flush input.
`timescale 1ns/1ps
module fq_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  output fq_entry_t     head,
  output logic [CW-1:0] count
);

  fq_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  // Popping an empty queue is a no-op.
  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: req/ack memory fetch, buffered queue, redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN presents an ack'd word in the same cycle when the queue is empty.
`timescale 1ns/1ps
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int          DEPTH    = 4,
  parameter  logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int          CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          deq,
  output logic          valid,
  output logic [31:0]   instr,
  output logic [31:0]   pc4,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fq_state_t     state, state_next;
  logic [31:0]   fpc, fpc_next, addr_next;
  logic [CW-1:0] fifo_count, count_after;
  logic          ack_take, bypass, push, pop, room_after, head_valid;
  fq_entry_t     head, push_data, shown, last_reg;

  assign ack_take  = (state == REQ) && imem_ack && !redirect;
  assign push_data = '{pc4: fpc + PC_STEP, instr: imem_rdata};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = ack_take && (fifo_count == '0);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word consumed in the same cycle never enters storage.
  assign push        = ack_take && !(bypass && deq);
  assign pop         = deq && (fifo_count != '0) && !redirect;
  assign count_after = fifo_count - CW'(pop);
  assign room_after  = (count_after + CW'(push)) < DEPTH_C;

  always_comb begin
    state_next = state;
    fpc_next   = fpc;
    addr_next  = imem_addr;
    if (redirect)      fpc_next = redirect_pc & ~32'd3;
    else if (ack_take) fpc_next = fpc + PC_STEP;
    case (state)
      IDLE: begin
        if (!redirect && (count_after < DEPTH_C)) begin
          state_next = REQ;
          addr_next  = fpc;
        end
      end
      REQ: begin
        if (redirect) begin
          // An unacked request must still complete; its data is thrown away.
          state_next = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          if (room_after) begin
            state_next = REQ;
            addr_next  = fpc_next;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      last_reg  <= '0;
    end else begin
      state     <= state_next;
      fpc       <= fpc_next;
      imem_req  <= (state_next != IDLE);
      imem_addr <= addr_next;
      if (valid) last_reg <= shown;
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // Outputs hold the last presented entry while nothing is valid.
  assign head_valid = (fifo_count != '0);
  assign valid      = head_valid || bypass;
  assign shown      = bypass ? push_data : head;
  assign instr      = valid ? shown.instr : last_reg.instr;
  assign pc4        = valid ? shown.pc4   : last_reg.pc4;
  assign count      = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory responder, address tracker and entry scoreboard.
`timescale 1ns/1ps
module tb_fetch_queue;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc4;
  logic [2:0]  count;

  int          compared   = 0;
  int          mismatched = 0;
  ent_t        exp_q[$];
  logic [31:0] exp_addr   = 32'h0;
  logic [31:0] req_addr_m = 32'h0;
  int          lat        = 2;
  int          mcnt       = 0;
  bit          drop_ack   = 0;
  bit          auto_deq   = 0;
  bit          prev_req   = 0;
  bit          prev_ack   = 0;
  bit          saw_wrap   = 0;
  logic [31:0] old_addr;
  int          nvalid;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .valid       (valid),
    .instr       (instr),
    .pc4         (pc4),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: bookkeeping for this cycle's inputs, edge, request tracking,
  // memory response, then head sampling and deq decision.
  task automatic tick();
    ent_t e;
    if (redirect) begin
      if (imem_req && !imem_ack) drop_ack = 1;
      exp_q.delete();
      exp_addr = redirect_pc & ~32'd3;
    end
    @(posedge clk);
    #1;
    if (imem_req && (!prev_req || prev_ack)) begin
      check("req_addr", imem_addr, exp_addr);
      req_addr_m = exp_addr;
      exp_addr   = exp_addr + 32'd4;
    end
    prev_req = imem_req;
    if (imem_req) begin
      if (mcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = word(imem_addr);
        mcnt       = 0;
        if (drop_ack) drop_ack = 0;
        else exp_q.push_back('{pc4: req_addr_m + 32'd4, instr: word(req_addr_m)});
      end else begin
        imem_ack = 1'b0;
        mcnt++;
      end
    end else begin
      imem_ack = 1'b0;
      mcnt     = 0;
    end
    prev_ack = imem_ack;
    #1;
    if (auto_deq && valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", valid, 1'b0);
        deq = 1'b0;
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", instr, e.instr);
        check("sb_pc4", pc4, e.pc4);
        if (instr === word(32'hFFFF_FFFC)) saw_wrap = 1;
        deq = 1'b1;
      end
    end else begin
      deq = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc4", pc4, 32'h0);
    check("rst_count", count, 3'd0);
    rst = 1'b1;

    // First word with a two-cycle memory, then fill with single-cycle acks.
    for (int i = 0; i < 20 && !valid; i++) tick();
    check("a_valid", valid, 1'b1);
    check("a_instr0", instr, word(32'h0));
    check("a_pc4_0", pc4, 32'h4);
    lat = 0;
    for (int i = 0; i < 40 && !(count == 3'd4 && !imem_req); i++) tick();
    check("b_full_count", count, 3'd4);
    repeat (5) tick();
    check("b_full_noreq", imem_req, 1'b0);
    check("b_full_count2", count, 3'd4);
    auto_deq = 1; tick(); auto_deq = 0; tick();
    for (int i = 0; i < 10 && !imem_req; i++) tick();
    check("b_resume_req", imem_req, 1'b1);
    check("b_resume_addr", imem_addr, 32'h10);
    auto_deq = 1; lat = 2;
    repeat (25) tick();

    // Redirect while a request is outstanding and unacked.
    lat = 5;
    for (int i = 0; i < 30 && !(imem_req && mcnt == 1); i++) tick();
    check("c_pending", imem_req, 1'b1);
    old_addr = imem_addr;
    redirect = 1'b1; redirect_pc = 32'h0040_0020;
    tick();
    redirect = 1'b0;
    check("c_valid0", valid, 1'b0);
    check("c_count0", count, 3'd0);
    check("c_req_held", imem_req, 1'b1);
    check("c_addr_held", imem_addr, old_addr);
    nvalid = 0;
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h0040_0020); i++) begin
      tick();
      if (valid) nvalid++;
    end
    check("c_new_addr", imem_addr, 32'h0040_0020);
    check("c_no_valid_gap", nvalid, 0);
    repeat (15) tick();

    // Redirect coinciding with an ack.
    auto_deq = 0; lat = 1;
    for (int i = 0; i < 30 && !(imem_ack && count != 3'd0); i++) tick();
    check("d_ack_seen", imem_ack, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h0000_1000;
    tick();
    redirect = 1'b0;
    check("d_count0", count, 3'd0);
    check("d_valid0", valid, 1'b0);
    for (int i = 0; i < 5 && !imem_req; i++) tick();
    check("d_new_addr", imem_addr, 32'h0000_1000);

    // Redirect to the top of the address space; low bits must be ignored.
    auto_deq = 1;
    repeat (6) tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    repeat (20) tick();
    check("e_saw_wrap", 32'(saw_wrap), 32'd1);

    // Asynchronous reset in the middle of a request.
    lat = 4;
    for (int i = 0; i < 30 && !(imem_req && mcnt == 2); i++) tick();
    #1 rst = 1'b0;
    #1;
    check("f_req", imem_req, 1'b0);
    check("f_addr", imem_addr, 32'h0);
    check("f_valid", valid, 1'b0);
    check("f_count", count, 3'd0);
    check("f_instr", instr, 32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete(); exp_addr = 32'h0; drop_ack = 0; mcnt = 0; deq = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    check("f_stale_count", count, 3'd0);
    check("f_stale_valid", valid, 1'b0);
    check("f_first_req", imem_req, 1'b1);
    check("f_first_addr", imem_addr, 32'h0);
    prev_req = 1'b0; prev_ack = 1'b0;
    repeat (25) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
